bar_level_tracker: RTL and testbench
====================================

# bar_level_tracker

Converts the 16-sample frames fetched from sample RAM into per-bar display heights and peak-hold markers for the bar-graph colour mapper. It sits directly downstream of the top-level RAM sample-fetch FSM. It accepts samples serially over a valid/ready handshake and double-buffers the bar heights so the display changes only on a frame tick. Per-bar peak markers hold for a fixed number of frames and then decay linearly.

## Interface
- NUM_BARS, 16, bars per frame; the sample index is log2(NUM_BARS) bits wide.
- MAX_HEIGHT, 400, height clamp in pixels; must fit in 9 bits.
- DECAY_STEP, 4, amount the peak drops per frame once its hold has expired.
- HOLD_FRAMES, 30, frames a new peak is held; the hold counter is 6 bits.
- Clk  in  1  system clock (50 MHz); single clock domain.
- Reset  in  1  synchronous, active-high.
- sample_in  in  16  signed two's-complement audio sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block accepts a sample this cycle; transfer occurs when valid && ready.
- frame_tick  in  1  one-cycle pulse per video frame, synchronised to Clk.
- bar_sel  in  4  bar index for the read port.
- bar_height  out  9  committed height of bar bar_sel, registered.
- peak_height  out  9  peak marker of bar bar_sel, registered.
- busy  out  1  high while the DECAY sweep runs.

## Operation
- Storage:
  - work[16] holds heights of the frame being assembled.
  - disp[16] holds the committed heights.
  - peak[16] holds the peak markers.
  - hold[16] holds the per-bar hold counters.
  - idx is the 4-bit sample index; pending flags a complete, uncommitted frame.
- States: IDLE and DECAY.
- sample_ready = (state==IDLE) && !pending.
- On accept:
  - mag = |sample_in|, with -32768 saturated to 32767.
  - h = min(mag>>6, MAX_HEIGHT).
  - work[idx] <= h.
  - If h >= peak[idx]: peak[idx] <= h and hold[idx] <= HOLD_FRAMES.
  - idx increments. On accepting idx==15, idx wraps to 0 and pending <= 1.
- frame_tick in IDLE:
  - If pending, disp <= work for all 16 bars (same cycle) and pending <= 0.
  - Always: state <= DECAY, sweep counter <= 0.
- DECAY processes one bar per cycle, bar j = 0..15:
  - If hold[j] != 0: hold[j] <= hold[j]-1.
  - Else: peak[j] <= (peak[j] > DECAY_STEP) ? peak[j]-DECAY_STEP : 0.
  - After bar 15 the state returns to IDLE.
- frame_tick during DECAY is ignored; it is not queued.
- A partial frame (idx != 0, pending==0) at a tick is not committed. disp is unchanged and idx keeps counting.
- Read port: bar_height <= disp[bar_sel] and peak_height <= peak[bar_sel] every cycle, including during DECAY.

## Timing
- Reset (synchronous) clears all arrays, holds, idx and pending; state becomes IDLE.
- Outputs in the cycle after Reset: bar_height=0, peak_height=0, busy=0, sample_ready=1.
- Reset mid-DECAY or mid-frame aborts immediately; no partial commit.
- Throughput: one sample per cycle while ready.
- Sample-to-work write latency: 1 cycle.
- Tick to disp update: 1 cycle.
- DECAY occupies exactly 16 cycles. busy is high for cycles 1..16 after the tick edge; sample_ready is 0 for the same cycles.
- Read latency: bar_sel to bar_height/peak_height is 1 cycle.
- Backpressure: after the 16th sample, sample_ready stays 0 until a tick commits the frame and DECAY completes. Upstream must hold sample_in/sample_valid stable while ready is low.
- Arithmetic: the magnitude is 15 bits unsigned, so mag>>6 has a maximum of 511 before the clamp. Peak decay floors at 0 and never wraps.

## Test plan
- Reset, then 16 samples of 0x1000, then a tick and 17 idle cycles. Required for each bar_sel 0..15: bar_height=64, peak_height=64, and busy high for exactly 16 cycles.
- Samples -32768, 0x7FFF, 0xFFC0 (-64) and 0x003F into bars 0..3, then a tick. Required: heights 400, 400, 1 and 0.
- 16 samples without a tick: sample_ready=0 after the 16th, and the 17th valid sample is held off. Tick: disp updates, ready returns to 1 exactly 17 cycles after the tick, and the held sample lands in bar 0.
- A frame of height 200, then all-zero frames each followed by one tick. Required: peak=200 through tick 30, 196 after tick 31, and 0 after tick 80. bar_height=0 from the second tick onward.
- Seven samples then a tick: bar_height unchanged. A second tick 5 cycles later, during DECAY, is ignored: busy stays high for exactly 16 cycles. The next sample is written to bar 7.
- Reset asserted in DECAY cycle 8 of a sweep: the next cycle shows all outputs at reset values and idx=0. A full frame afterwards commits correctly.

Source files
------------

// File: rtl/bar_level_tracker.sv
// Serial sample-to-bar-height converter with a double-buffered display copy and
// per-bar peak markers that hold for a fixed number of frames, then decay linearly.
module bar_level_tracker #(
    parameter int NUM_BARS    = 16,
    parameter int MAX_HEIGHT  = 400,
    parameter int DECAY_STEP  = 4,
    parameter int HOLD_FRAMES = 30,
    parameter int DATA_W      = 16,
    localparam int IDX_W      = $clog2(NUM_BARS),
    localparam int H_W        = 9
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic signed [DATA_W-1:0] i_sample_in,
    input  logic                     i_sample_valid,
    output logic                     o_sample_ready,
    input  logic                     i_frame_tick,
    input  logic [IDX_W-1:0]         i_bar_sel,
    output logic [H_W-1:0]           o_bar_height,
    output logic [H_W-1:0]           o_peak_height,
    output logic                     o_busy
);

    localparam int HOLD_W = 6;
    localparam logic [IDX_W-1:0] LAST_BAR = IDX_W'(NUM_BARS - 1);

    typedef enum logic {S_IDLE, S_DECAY} state_t;

    state_t                 r_state, w_state_nxt;
    logic [H_W-1:0]         r_work [NUM_BARS];
    logic [H_W-1:0]         r_disp [NUM_BARS];
    logic [H_W-1:0]         r_peak [NUM_BARS];
    logic [HOLD_W-1:0]      r_hold [NUM_BARS];
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_sweep;
    logic                   r_pending;
    logic [H_W-1:0]         r_bar_height, r_peak_height;
    logic                   w_vld_p0;
    logic [H_W-1:0]         w_height_p0;

    // |s| saturated to the positive range, scaled down by 64, clamped to the display height.
    function automatic logic [H_W-1:0] height_of(input logic signed [DATA_W-1:0] s);
        logic [DATA_W-2:0] mag;
        logic [DATA_W-2:0] sh;
        if (!s[DATA_W-1])
            mag = s[DATA_W-2:0];
        else if (s[DATA_W-2:0] == '0)
            mag = '1;
        else
            mag = ~s[DATA_W-2:0] + 1'b1;
        sh = mag >> 6;
        if (sh > (DATA_W-1)'(MAX_HEIGHT))
            return H_W'(MAX_HEIGHT);
        return H_W'(sh);
    endfunction

    function automatic logic [H_W-1:0] decayed(input logic [H_W-1:0] p);
        return (p > H_W'(DECAY_STEP)) ? p - H_W'(DECAY_STEP) : '0;
    endfunction

    assign o_sample_ready = (r_state == S_IDLE) && !r_pending;
    assign o_busy         = (r_state == S_DECAY);
    assign o_bar_height   = r_bar_height;
    assign o_peak_height  = r_peak_height;
    assign w_vld_p0       = i_sample_valid && o_sample_ready;
    assign w_height_p0    = height_of(i_sample_in);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_frame_tick) w_state_nxt = S_DECAY;
            S_DECAY: if (r_sweep == LAST_BAR) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Stage p0 -> storage: sample write, frame commit, decay sweep and read port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                r_work[i] <= '0;
                r_disp[i] <= '0;
                r_peak[i] <= '0;
                r_hold[i] <= '0;
            end
            r_idx         <= '0;
            r_sweep       <= '0;
            r_pending     <= 1'b0;
            r_bar_height  <= '0;
            r_peak_height <= '0;
        end else begin
            r_bar_height  <= r_disp[i_bar_sel];
            r_peak_height <= r_peak[i_bar_sel];

            if (r_state == S_IDLE && i_frame_tick) begin
                if (r_pending) begin
                    for (int i = 0; i < NUM_BARS; i++)
                        r_disp[i] <= r_work[i];
                    r_pending <= 1'b0;
                end
                r_sweep <= '0;
            end

            if (r_state == S_DECAY) begin
                if (r_hold[r_sweep] != '0)
                    r_hold[r_sweep] <= r_hold[r_sweep] - 1'b1;
                else
                    r_peak[r_sweep] <= decayed(r_peak[r_sweep]);
                r_sweep <= r_sweep + 1'b1;
            end

            // Accept is only possible in IDLE with no pending frame, so it never
            // collides with the commit or the sweep above.
            if (w_vld_p0) begin
                r_work[r_idx] <= w_height_p0;
                if (w_height_p0 >= r_peak[r_idx]) begin
                    r_peak[r_idx] <= w_height_p0;
                    r_hold[r_idx] <= HOLD_W'(HOLD_FRAMES);
                end
                if (r_idx == LAST_BAR) begin
                    r_idx     <= '0;
                    r_pending <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bar_level_tracker.sv
// Bench for bar_level_tracker: a fixed vector table, directed multi-cycle sequences,
// and randomized traffic checked every cycle against a frame-level reference model.
module tb_bar_level_tracker;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_in;
    logic               vld;
    logic               tick;
    logic [3:0]         sel;
    logic               o_ready;
    logic [8:0]         o_bar;
    logic [8:0]         o_peak;
    logic               o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    bar_level_tracker dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_sample_in    (s_in),
        .i_sample_valid (vld),
        .o_sample_ready (o_ready),
        .i_frame_tick   (tick),
        .i_bar_sel      (sel),
        .o_bar_height   (o_bar),
        .o_peak_height  (o_peak),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_work [16];
    int m_disp [16];
    int m_peak [16];
    int m_hold [16];
    int m_idx, m_pending, m_left, m_bh, m_ph;

    function automatic int ref_height(input logic signed [15:0] s);
        int v, mag, h;
        v   = s;
        mag = (v < 0) ? -v : v;
        if (mag > 32767) mag = 32767;
        h = mag / 64;
        return (h > 400) ? 400 : h;
    endfunction

    task automatic model_edge();
        int bh, ph, rdy, j, h;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_work[i] = 0; m_disp[i] = 0; m_peak[i] = 0; m_hold[i] = 0;
            end
            m_idx = 0; m_pending = 0; m_left = 0; m_bh = 0; m_ph = 0;
            return;
        end
        bh  = m_disp[sel];
        ph  = m_peak[sel];
        rdy = (m_left == 0) && (m_pending == 0);
        if (m_left > 0) begin
            j = 16 - m_left;
            if (m_hold[j] > 0) m_hold[j] = m_hold[j] - 1;
            else m_peak[j] = (m_peak[j] > 4) ? m_peak[j] - 4 : 0;
            m_left = m_left - 1;
        end else if (tick) begin
            if (m_pending != 0) begin
                m_disp = m_work;
                m_pending = 0;
            end
            m_left = 16;
        end
        if (vld && rdy) begin
            h = ref_height(s_in);
            m_work[m_idx] = h;
            if (h >= m_peak[m_idx]) begin
                m_peak[m_idx] = h;
                m_hold[m_idx] = 30;
            end
            m_idx = (m_idx + 1) % 16;
            if (m_idx == 0) m_pending = 1;
        end
        m_bh = bh;
        m_ph = ph;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_bar_height", o_bar, m_bh);
        chk("model_peak_height", o_peak, m_ph);
        chk("model_ready", o_ready, (m_left == 0 && m_pending == 0) ? 1 : 0);
        chk("model_busy", o_busy, (m_left > 0) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        vld = 1'b0; tick = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; tick = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic signed [15:0] v);
        for (int i = 0; i < 16; i++) begin
            s_in = v; vld = 1'b1;
            step();
        end
        vld = 1'b0;
    endtask

    task automatic tick_and_settle();
        tick = 1'b1;
        step();
        tick = 1'b0;
        idle(17);
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] s;
        logic        v;
        logic        t;
        logic [3:0]  sel;
        int          rep;
        int          bar;
        int          pk;
        int          rdy;
        int          bsy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int cnt, exp_pk;
        rst = 1'b1; s_in = '0; vld = 1'b0; tick = 1'b0; sel = '0;

        // Vector table: saturation/clamp/rounding samples into bars 0..3, then commit.
        tbl[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1,  0,   0,   1, 0};
        tbl[1]  = '{1'b0, 16'h8000, 1'b1, 1'b0, 4'd0, 1,  0,   0,   1, 0};
        tbl[2]  = '{1'b0, 16'h7FFF, 1'b1, 1'b0, 4'd0, 1,  0,   400, 1, 0};
        tbl[3]  = '{1'b0, 16'hFFC0, 1'b1, 1'b0, 4'd1, 1,  0,   400, 1, 0};
        tbl[4]  = '{1'b0, 16'h003F, 1'b1, 1'b0, 4'd2, 1,  0,   1,   1, 0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 11, 0,   0,   1, 0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3, 1,  0,   0,   0, 0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1,  0,   400, 0, 1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1,  400, 400, 0, 1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1,  400, 400, 0, 1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd2, 1,  1,   1,   0, 1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 1,  0,   0,   0, 1};
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                rst = tbl[r].rst; s_in = tbl[r].s; vld = tbl[r].v;
                tick = tbl[r].t; sel = tbl[r].sel;
                step();
                chk("vec_bar", o_bar, tbl[r].bar);
                chk("vec_peak", o_peak, tbl[r].pk);
                chk("vec_ready", o_ready, tbl[r].rdy);
                chk("vec_busy", o_busy, tbl[r].bsy);
            end
        end
        rst = 1'b0;
        idle(14);

        // Basic frame: 16 x 0x1000 gives height 64 everywhere, 16-cycle busy.
        do_reset();
        chk("reset_ready", o_ready, 1);
        chk("reset_busy", o_busy, 0);
        send_frame(16'sh1000);
        cnt = 0;
        tick = 1'b1; step(); cnt += o_busy; tick = 1'b0;
        for (int i = 0; i < 17; i++) begin step(); cnt += o_busy; end
        chk("busy_len", cnt, 16);
        for (int b = 0; b < 16; b++) begin
            sel = 4'(b); step();
            chk("frame64_bar", o_bar, 64);
            chk("frame64_peak", o_peak, 64);
        end

        // Backpressure: 17th sample held off until commit + sweep completes.
        do_reset();
        send_frame(16'sh2000);
        s_in = 16'sh3000; vld = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); chk("held_off_ready", o_ready, 0); end
        cnt = 0;
        tick = 1'b1;
        do begin step(); tick = 1'b0; cnt++; end while (!o_ready && cnt < 40);
        chk("ready_return_cycles", cnt, 17);
        step();
        vld = 1'b0; sel = 4'd0;
        idle(2);
        chk("held_sample_peak_bar0", o_peak, 192);
        chk("committed_bar0", o_bar, 128);

        // Peak hold then linear decay over 80 frames.
        do_reset();
        send_frame(16'sh3200);
        sel = 4'd5;
        for (int k = 1; k <= 80; k++) begin
            tick_and_settle();
            exp_pk = (k <= 30) ? 200 : 200 - 4 * (k - 30);
            if (exp_pk < 0) exp_pk = 0;
            chk("decay_peak", o_peak, exp_pk);
            chk("decay_bar", o_bar, (k == 1) ? 200 : 0);
            if (k < 80) send_frame(16'sh0000);
        end

        // Partial frame at tick, tick during DECAY ignored, idx keeps counting.
        do_reset();
        send_frame(16'sh1000);
        tick_and_settle();
        for (int i = 0; i < 7; i++) begin s_in = 16'sh2000; vld = 1'b1; step(); end
        vld = 1'b0;
        cnt = 0;
        tick = 1'b1; step(); cnt += o_busy; tick = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); cnt += o_busy; end
        tick = 1'b1; step(); cnt += o_busy; tick = 1'b0;
        for (int i = 0; i < 14; i++) begin step(); cnt += o_busy; end
        chk("ignored_tick_busy_len", cnt, 16);
        sel = 4'd0; step();
        chk("partial_bar_unchanged", o_bar, 64);
        s_in = 16'sh3000; vld = 1'b1; step(); vld = 1'b0;
        sel = 4'd7; idle(2);
        chk("next_sample_bar7_peak", o_peak, 192);
        sel = 4'd8; idle(2);
        chk("bar8_untouched_peak", o_peak, 64);
        sel = 4'd0; idle(2);
        chk("bar0_partial_peak", o_peak, 128);

        // Reset in DECAY cycle 8 aborts; next frame lands from bar 0.
        do_reset();
        send_frame(16'sh1000);
        tick_and_settle();
        send_frame(16'sh2000);
        sel = 4'd0;
        tick = 1'b1; step(); tick = 1'b0;
        idle(7);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midreset_bar", o_bar, 0);
        chk("midreset_peak", o_peak, 0);
        chk("midreset_busy", o_busy, 0);
        chk("midreset_ready", o_ready, 1);
        for (int i = 0; i < 16; i++) begin
            s_in = 16'((i * 10 + 5) * 64); vld = 1'b1; step();
        end
        vld = 1'b0;
        tick_and_settle();
        for (int b = 0; b < 16; b++) begin
            sel = 4'(b); step();
            chk("post_reset_frame_bar", o_bar, b * 10 + 5);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 599) == 0);
            vld  = ($urandom_range(0, 9) < 7);
            tick = ($urandom_range(0, 24) == 0);
            s_in = 16'($urandom);
            sel  = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0; vld = 1'b0; tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
